mips_prog_loader: RTL and testbench

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

---
 rtl/mips_prog_loader.sv | 137 +++++++++++++
 tb/tb_mips_prog_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// Byte-stream program loader: receives a header word count, big-endian data words
// and an XOR checksum, writes the words to instruction memory and releases the CPU.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, CPU held, waiting for start
// S_HDR   | waiting for the header byte (word count N)
// S_DATA  | collecting the four bytes of the current word
// S_WRITE | one-cycle memory write strobe of the assembled word
// S_CHK   | waiting for the checksum byte
// S_DONE  | load succeeded, CPU released, waiting for a reload start
// S_ERR   | load failed, CPU held, waiting for a retry start
module mips_prog_loader #(
   parameter int MEM_WORDS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        cpu_rstn,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [8:0] MAX_WORDS = 9'(MEM_WORDS);

   state_t      state;
   logic [7:0]  n_words;
   logic [7:0]  index;
   logic [1:0]  byte_cnt;
   logic [7:0]  chk;
   logic [31:0] word;
   logic [31:0] word_next;
   logic        xfer;
   logic        hdr_bad;

   assign byte_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
   assign xfer       = byte_valid & byte_ready;
   assign word_next  = {word[23:0], byte_data};
   assign hdr_bad    = (byte_data == 8'd0) || ({1'b0, byte_data} > MAX_WORDS);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= S_IDLE;
         n_words  <= 8'd0;
         index    <= 8'd0;
         byte_cnt <= 2'd0;
         chk      <= 8'd0;
         word     <= 32'd0;
         mem_we   <= 1'b0;
         mem_addr <= 32'd0;
         mem_wd   <= 32'd0;
         cpu_rstn <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state    <= S_HDR;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  cpu_rstn <= 1'b0;
                  busy     <= 1'b1;
                  index    <= 8'd0;
                  byte_cnt <= 2'd0;
                  chk      <= 8'd0;
               end
            end
            S_HDR: begin
               if (xfer) begin
                  if (hdr_bad) begin
                     state <= S_ERR;
                     err   <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     n_words <= byte_data;
                     state   <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  word     <= word_next;
                  chk      <= chk ^ byte_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  // strobe is registered so it coincides with the WRITE state
                  if (byte_cnt == 2'd3) begin
                     state    <= S_WRITE;
                     mem_we   <= 1'b1;
                     mem_addr <= {22'd0, index, 2'b00};
                     mem_wd   <= word_next;
                  end
               end
            end
            S_WRITE: begin
               index <= index + 8'd1;
               if (index == n_words - 8'd1) state <= S_CHK;
               else                         state <= S_DATA;
            end
            S_CHK: begin
               if (xfer) begin
                  busy <= 1'b0;
                  if (byte_data == chk) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_rstn <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: expected writes are queued as streams are
// built and popped by a monitor whenever the loader strobes mem_we.
module tb_mips_prog_loader;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        cpu_rstn;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   cyc = 0;
   int   hdr_cyc = 0;
   int   end_cyc = 0;
   logic [7:0] stream[$];
   wr_t  exp_q[$];
   wr_t  got;

   mips_prog_loader #(.MEM_WORDS(16)) dut (
      .CLK(CLK), .RST(RST), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard side: every write strobe must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (mem_we) begin
         if (exp_q.size() == 0) begin
            check("spurious_we", 32'(exp_q.size()), 32'd1);
         end else begin
            got = exp_q.pop_front();
            check("wr_addr", mem_addr, got.addr);
            check("wr_data", mem_wd, got.data);
         end
      end
   end

   task automatic build_basic(input logic [7:0] last);
      wr_t w;
      stream = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h40, 8'h20, last};
      w.addr = 32'h0; w.data = 32'h2008_0005; exp_q.push_back(w);
      w.addr = 32'h4; w.data = 32'h0109_4020; exp_q.push_back(w);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at a negedge. start is held high for the first
   // start_hold bytes to show it is ignored while busy.
   task automatic drive_stream(input bit gaps, input int start_hold, input int budget);
      int  i = 0;
      int  n = 0;
      bit  xf;
      while (i < stream.size() && n < budget) begin
         start      = (i < start_hold);
         byte_data  = stream[i];
         byte_valid = !(gaps && byte_ready && ($urandom_range(0, 2) == 0));
         xf = byte_valid && byte_ready;
         if (xf && i == 0) hdr_cyc = cyc;
         @(posedge CLK);
         if (xf) i++;
         n++;
         @(negedge CLK);
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      if (i < stream.size()) check("stream_timeout", 32'(i), 32'(stream.size()));
   endtask

   task automatic wait_end(input int budget);
      int w = 0;
      while (!(done || err) && w < budget) begin
         @(negedge CLK);
         w++;
      end
      end_cyc = cyc;
      if (!(done || err)) check("end_timeout", {30'd0, done, err}, 32'd2);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "_we"},    32'(mem_we), 32'd0);
      check({tag, "_addr"},  mem_addr, 32'd0);
      check({tag, "_wd"},    mem_wd, 32'd0);
      check({tag, "_rstn"},  32'(cpu_rstn), 32'd0);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
      check({tag, "_err"},   32'(err), 32'd0);
   endtask

   initial begin
      logic [7:0]  c;
      logic [31:0] d;
      wr_t         w;

      // reset state
      #12;
      check_reset_outputs("rst");
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check("idle_rstn", 32'(cpu_rstn), 32'd0);

      // basic load with latency
      build_basic(8'h45);
      pulse_start();
      check("start_busy", 32'(busy), 32'd1);
      check("start_ready", 32'(byte_ready), 32'd1);
      drive_stream(1'b0, 0, 60);
      wait_end(20);
      check("basic_done", 32'(done), 32'd1);
      check("basic_err", 32'(err), 32'd0);
      check("basic_rstn", 32'(cpu_rstn), 32'd1);
      check("basic_busy", 32'(busy), 32'd0);
      check("basic_latency", 32'(end_cyc - hdr_cyc), 32'd12);
      check("basic_left", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge CLK);
      check("hold_addr", mem_addr, 32'h4);
      check("hold_wd", mem_wd, 32'h0109_4020);

      // reload from DONE, start held during HDR/DATA must be ignored
      stream = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      w.addr = 32'h0; w.data = 32'hAABB_CCDD; exp_q.push_back(w);
      pulse_start();
      check("reload_rstn", 32'(cpu_rstn), 32'd0);
      check("reload_done", 32'(done), 32'd0);
      check("reload_busy", 32'(busy), 32'd1);
      drive_stream(1'b0, 3, 40);
      wait_end(20);
      check("reload_ok", 32'(done), 32'd1);
      check("reload_latency", 32'(end_cyc - hdr_cyc), 32'd7);
      check("reload_left", 32'(exp_q.size()), 32'd0);

      // header 0
      stream = '{8'h00};
      pulse_start();
      drive_stream(1'b0, 0, 10);
      check("hdr0_err", 32'(err), 32'd1);
      check("hdr0_busy", 32'(busy), 32'd0);
      check("hdr0_rstn", 32'(cpu_rstn), 32'd0);
      check("hdr0_done", 32'(done), 32'd0);

      // header 17
      stream = '{8'h11};
      pulse_start();
      drive_stream(1'b0, 0, 10);
      check("hdr17_err", 32'(err), 32'd1);
      check("hdr17_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge CLK);

      // header 16: full memory
      stream = '{8'h10};
      c = 8'h00;
      for (int k = 0; k < 16; k++) begin
         d = $urandom;
         for (int b = 3; b >= 0; b--) begin
            stream.push_back(d[b*8 +: 8]);
            c = c ^ d[b*8 +: 8];
         end
         w.addr = 32'(k * 4); w.data = d; exp_q.push_back(w);
      end
      stream.push_back(c);
      pulse_start();
      drive_stream(1'b0, 0, 200);
      wait_end(20);
      check("hdr16_done", 32'(done), 32'd1);
      check("hdr16_err", 32'(err), 32'd0);
      check("hdr16_latency", 32'(end_cyc - hdr_cyc), 32'd82);
      check("hdr16_left", 32'(exp_q.size()), 32'd0);

      // bad checksum: writes stay, error reported
      build_basic(8'h44);
      pulse_start();
      drive_stream(1'b0, 0, 60);
      wait_end(20);
      check("badchk_err", 32'(err), 32'd1);
      check("badchk_done", 32'(done), 32'd0);
      check("badchk_rstn", 32'(cpu_rstn), 32'd0);
      check("badchk_left", 32'(exp_q.size()), 32'd0);

      // handshake gaps
      build_basic(8'h45);
      pulse_start();
      drive_stream(1'b1, 0, 200);
      wait_end(20);
      check("gap_done", 32'(done), 32'd1);
      check("gap_err", 32'(err), 32'd0);
      check("gap_rstn", 32'(cpu_rstn), 32'd1);
      check("gap_left", 32'(exp_q.size()), 32'd0);

      // reset after the 3rd data byte
      stream = '{8'h02, 8'h20, 8'h08, 8'h00};
      pulse_start();
      drive_stream(1'b0, 0, 20);
      byte_valid = 1'b1;
      byte_data  = 8'h05;
      #2 RST = 1'b1;
      #1;
      check_reset_outputs("midrst");
      byte_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      repeat (6) @(negedge CLK);
      check("midrst_idle_busy", 32'(busy), 32'd0);
      build_basic(8'h45);
      pulse_start();
      drive_stream(1'b0, 0, 60);
      wait_end(20);
      check("midrst_done", 32'(done), 32'd1);
      check("midrst_rstn", 32'(cpu_rstn), 32'd1);
      check("midrst_left", 32'(exp_q.size()), 32'd0);

      repeat (2) @(negedge CLK);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
